// File: rtl/sram_access_arbiter_if.sv
// Requester handshake and SRAM control/address signals for sram_access_arbiter.
// The master modport is the arbiter side; slave is the effects section plus SRAM.
interface sram_access_arbiter_if;
    logic        REQ0;
    logic        REQ1;
    logic        WE0;
    logic        WE1;
    logic [19:0] ADDR0;
    logic [19:0] ADDR1;
    logic [15:0] WDATA0;
    logic [15:0] WDATA1;
    logic        ACK0;
    logic        ACK1;
    logic [15:0] RDATA0;
    logic [15:0] RDATA1;
    logic        BUSY;
    logic [19:0] SRAMaddress;
    logic        SRAM_nCE;
    logic        SRAM_nOE;
    logic        SRAM_nWE;
    logic        SRAM_nUB;
    logic        SRAM_nLB;

    modport master (
        input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1,
        output ACK0, ACK1, RDATA0, RDATA1, BUSY,
        output SRAMaddress, SRAM_nCE, SRAM_nOE, SRAM_nWE, SRAM_nUB, SRAM_nLB
    );

    modport slave (
        output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1,
        input  ACK0, ACK1, RDATA0, RDATA1, BUSY,
        input  SRAMaddress, SRAM_nCE, SRAM_nOE, SRAM_nWE, SRAM_nUB, SRAM_nLB
    );
endinterface

// File: rtl/sram_access_arbiter.sv
// Round-robin arbiter giving two audio requesters fixed-length read/write
// access to the external 1M x 16 async SRAM, with fully registered strobes.
module sram_access_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  CLOCK50M,
    input  logic                  RESET,
    sram_access_arbiter_if.master bus,
    inout  wire  [15:0]           SRAMdata
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q;
    logic        last_q;
    logic        grant_q, grant_d;
    logic [1:0]  mask_q;
    logic        we_q;
    logic        drive_q;
    logic [19:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata0_q, rdata1_q;
    logic        nCe_q, nOe_q, nWe_q;
    logic        ack0_q, ack1_q, busy_q;
    logic        req0, req1;
    logic        selWe;
    logic [19:0] selAddr;
    logic [15:0] selWdata;

    always_comb begin
        req0     = bus.REQ0 & ~mask_q[0];
        req1     = bus.REQ1 & ~mask_q[1];
        // On a tie the requester that was not served last wins.
        grant_d  = req1 & (~req0 | ~last_q);
        selWe    = grant_d ? bus.WE1    : bus.WE0;
        selAddr  = grant_d ? bus.ADDR1  : bus.ADDR0;
        selWdata = grant_d ? bus.WDATA1 : bus.WDATA0;
        state_d  = state_q;
        case (state_q)
            IDLE:    if (req0 | req1) state_d = SETUP;
            SETUP:   state_d = STROBE;
            STROBE:  if (cnt_q == WAIT_LAST) state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK50M) begin
        if (RESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            grant_q  <= 1'b0;
            mask_q   <= '0;
            we_q     <= 1'b0;
            drive_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            nCe_q    <= 1'b1;
            nOe_q    <= 1'b1;
            nWe_q    <= 1'b1;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    mask_q <= 2'b00;
                    if (state_d == SETUP) begin
                        grant_q <= grant_d;
                        last_q  <= grant_d;
                        we_q    <= selWe;
                        addr_q  <= selAddr;
                        wdata_q <= selWdata;
                        nCe_q   <= 1'b0;
                        nOe_q   <= selWe;
                        nWe_q   <= 1'b1;
                        drive_q <= selWe;
                    end
                end
                SETUP: begin
                    cnt_q <= '0;
                    nWe_q <= ~we_q;
                end
                STROBE: begin
                    // Read data goes straight into RDATA on the last strobe edge so it is valid alongside ACK.
                    if (state_d == HOLD) begin
                        nWe_q  <= 1'b1;
                        ack0_q <= ~grant_q;
                        ack1_q <= grant_q;
                        if (!we_q) begin
                            if (grant_q) rdata1_q <= SRAMdata;
                            else         rdata0_q <= SRAMdata;
                        end
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                HOLD: begin
                    nCe_q   <= 1'b1;
                    nOe_q   <= 1'b1;
                    drive_q <= 1'b0;
                    mask_q  <= grant_q ? 2'b10 : 2'b01;
                end
                default: ;
            endcase
        end
    end

    assign bus.ACK0        = ack0_q;
    assign bus.ACK1        = ack1_q;
    assign bus.RDATA0      = rdata0_q;
    assign bus.RDATA1      = rdata1_q;
    assign bus.BUSY        = busy_q;
    assign bus.SRAMaddress = addr_q;
    assign bus.SRAM_nCE    = nCe_q;
    assign bus.SRAM_nOE    = nOe_q;
    assign bus.SRAM_nWE    = nWe_q;
    assign bus.SRAM_nUB    = nCe_q;
    assign bus.SRAM_nLB    = nCe_q;
    assign SRAMdata        = drive_q ? wdata_q : 16'hzzzz;
endmodule

// File: tb/tb_sram_access_arbiter.sv
// Self-checking bench for sram_access_arbiter: cycle-by-cycle vector table
// against a behavioural SRAM, plus directed multi-cycle sequences.
module tb_sram_access_arbiter;
    localparam logic [7:0] IDLE_S = 8'b1111_1000;
    localparam logic [7:0] RD_S   = 8'b0010_0001;
    localparam logic [7:0] RD_H   = 8'b0010_0011;
    localparam logic [7:0] WR_SU  = 8'b0110_0001;
    localparam logic [7:0] WR_ST  = 8'b0100_0001;
    localparam logic [7:0] WR_H   = 8'b0110_0101;

    // strobes = {nCE, nOE, nWE, nUB, nLB, ACK0, ACK1, BUSY}
    typedef struct {
        logic        req0;
        logic        we0;
        logic [19:0] addr0;
        logic [15:0] wdata0;
        logic        req1;
        logic [19:0] addr1;
        logic [7:0]  strobes;
        logic        addrChk;
        logic [19:0] addrExp;
        logic        dataChk;
        logic [15:0] dataExp;
        logic [15:0] rdata1Exp;
    } vec_t;

    logic        clock;
    logic        reset;
    int          checks;
    int          errors;
    int          nAck;
    int          ackAt [4];
    logic        ackWho [4];
    int          ack3At;
    logic [15:0] rd3;
    logic [15:0] noeMask;
    logic [15:0] mem [0:1023];
    vec_t        vecs [0:17];

    sram_access_arbiter_if bus();
    sram_access_arbiter_if bus3();
    wire [15:0] sramData;
    wire [15:0] sramData3;

    sram_access_arbiter #(.WAIT_CYCLES(1)) dut (
        .CLOCK50M(clock),
        .RESET(reset),
        .bus(bus),
        .SRAMdata(sramData)
    );

    sram_access_arbiter #(.WAIT_CYCLES(3)) dut3 (
        .CLOCK50M(clock),
        .RESET(reset),
        .bus(bus3),
        .SRAMdata(sramData3)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    // Behavioural async SRAM: drives on read, commits on rising nWE.
    assign sramData = (!bus.SRAM_nCE && !bus.SRAM_nOE && bus.SRAM_nWE) ?
                      mem[bus.SRAMaddress[9:0]] : 16'hzzzz;
    always @(posedge bus.SRAM_nWE) begin
        if (!bus.SRAM_nCE) mem[bus.SRAMaddress[9:0]] = sramData;
    end
    assign sramData3 = (!bus3.SRAM_nCE && !bus3.SRAM_nOE) ? 16'h5A5A : 16'hzzzz;

    function automatic vec_t mk(input logic r0, input logic w0, input logic [19:0] a0,
                                input logic [15:0] d0, input logic r1, input logic [19:0] a1,
                                input logic [7:0] st, input logic aChk, input logic [19:0] aExp,
                                input logic dChk, input logic [15:0] dExp, input logic [15:0] rd1);
        vec_t v;
        v.req0 = r0; v.we0 = w0; v.addr0 = a0; v.wdata0 = d0;
        v.req1 = r1; v.addr1 = a1; v.strobes = st;
        v.addrChk = aChk; v.addrExp = aExp;
        v.dataChk = dChk; v.dataExp = dExp; v.rdata1Exp = rd1;
        return v;
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] strobesNow();
        return {bus.SRAM_nCE, bus.SRAM_nOE, bus.SRAM_nWE, bus.SRAM_nUB, bus.SRAM_nLB,
                bus.ACK0, bus.ACK1, bus.BUSY};
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.REQ0   = v.req0;
        bus.WE0    = v.we0;
        bus.ADDR0  = v.addr0;
        bus.WDATA0 = v.wdata0;
        bus.REQ1   = v.req1;
        bus.WE1    = 1'b0;
        bus.ADDR1  = v.addr1;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        compare($sformatf("vec%0d_strobes", idx), 32'(strobesNow()), 32'(v.strobes));
        if (v.addrChk) compare($sformatf("vec%0d_addr", idx), 32'(bus.SRAMaddress), 32'(v.addrExp));
        if (v.dataChk) compare($sformatf("vec%0d_data", idx), 32'(sramData), 32'(v.dataExp));
        compare($sformatf("vec%0d_rdata1", idx), 32'(bus.RDATA1), 32'(v.rdata1Exp));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.REQ0 = 0; bus.REQ1 = 0; bus.WE0 = 0; bus.WE1 = 0;
        bus.ADDR0 = '0; bus.ADDR1 = '0; bus.WDATA0 = '0; bus.WDATA1 = '0;
        bus3.REQ0 = 0; bus3.REQ1 = 0; bus3.WE0 = 0; bus3.WE1 = 0;
        bus3.ADDR0 = '0; bus3.ADDR1 = '0; bus3.WDATA0 = '0; bus3.WDATA1 = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[10'h123] = 16'h1234;

        // Read 1234 by requester 1, write BEEF by requester 0, read back BEEF.
        vecs[0]  = mk(0, 0, 20'h0, 16'h0, 1, 20'h00123, IDLE_S, 0, 20'h0, 0, 16'h0, 16'h0000);
        vecs[1]  = mk(0, 0, 20'h0, 16'h0, 1, 20'h00123, RD_S, 1, 20'h00123, 1, 16'h1234, 16'h0000);
        vecs[2]  = mk(0, 0, 20'h0, 16'h0, 1, 20'h0FFFF, RD_S, 1, 20'h00123, 1, 16'h1234, 16'h0000);
        vecs[3]  = mk(0, 0, 20'h0, 16'h0, 1, 20'h00123, RD_S, 1, 20'h00123, 1, 16'h1234, 16'h0000);
        vecs[4]  = mk(0, 0, 20'h0, 16'h0, 1, 20'h00123, RD_H, 1, 20'h00123, 1, 16'h1234, 16'h1234);
        vecs[5]  = mk(0, 0, 20'h0, 16'h0, 0, 20'h0, IDLE_S, 0, 20'h0, 0, 16'h0, 16'h1234);
        vecs[6]  = mk(1, 1, 20'h00123, 16'hBEEF, 0, 20'h0, IDLE_S, 0, 20'h0, 0, 16'h0, 16'h1234);
        vecs[7]  = mk(1, 1, 20'h00123, 16'hBEEF, 0, 20'h0, WR_SU, 1, 20'h00123, 1, 16'hBEEF, 16'h1234);
        vecs[8]  = mk(1, 1, 20'h00123, 16'h0000, 0, 20'h0, WR_ST, 1, 20'h00123, 1, 16'hBEEF, 16'h1234);
        vecs[9]  = mk(1, 1, 20'h00123, 16'hBEEF, 0, 20'h0, WR_ST, 1, 20'h00123, 1, 16'hBEEF, 16'h1234);
        vecs[10] = mk(1, 1, 20'h00123, 16'hBEEF, 0, 20'h0, WR_H, 1, 20'h00123, 1, 16'hBEEF, 16'h1234);
        vecs[11] = mk(0, 0, 20'h0, 16'h0, 0, 20'h0, IDLE_S, 0, 20'h0, 0, 16'h0, 16'h1234);
        vecs[12] = mk(0, 0, 20'h0, 16'h0, 1, 20'h00123, IDLE_S, 0, 20'h0, 0, 16'h0, 16'h1234);
        vecs[13] = mk(0, 0, 20'h0, 16'h0, 1, 20'h00123, RD_S, 1, 20'h00123, 1, 16'hBEEF, 16'h1234);
        vecs[14] = mk(0, 0, 20'h0, 16'h0, 1, 20'h00123, RD_S, 1, 20'h00123, 1, 16'hBEEF, 16'h1234);
        vecs[15] = mk(0, 0, 20'h0, 16'h0, 1, 20'h00123, RD_S, 1, 20'h00123, 1, 16'hBEEF, 16'h1234);
        vecs[16] = mk(0, 0, 20'h0, 16'h0, 1, 20'h00123, RD_H, 1, 20'h00123, 1, 16'hBEEF, 16'hBEEF);
        vecs[17] = mk(0, 0, 20'h0, 16'h0, 0, 20'h0, IDLE_S, 0, 20'h0, 0, 16'h0, 16'hBEEF);

        repeat (2) @(negedge clock);
        compare("reset_strobes", 32'(strobesNow()), 32'(IDLE_S));
        compare("reset_addr", 32'(bus.SRAMaddress), 32'h0);
        compare("reset_rdata0", 32'(bus.RDATA0), 32'h0);
        compare("reset_rdata1", 32'(bus.RDATA1), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            @(negedge clock);
            checkOutput(vecs[i], i);
            applyStimulus(vecs[i]);
        end

        // Tie with both requesters held high: grants alternate 0,1,0,1 every 5 cycles.
        @(negedge clock);
        bus.REQ0 = 1; bus.WE0 = 0; bus.ADDR0 = 20'h00123;
        bus.REQ1 = 1; bus.WE1 = 0; bus.ADDR1 = 20'h00123;
        nAck = 0;
        for (int k = 0; k < 4; k++) begin ackAt[k] = -1; ackWho[k] = 1'bx; end
        for (int c = 1; c <= 40 && nAck < 4; c++) begin
            @(negedge clock);
            if (bus.ACK0 || bus.ACK1) begin
                compare("tie_single_ack", 32'(bus.ACK0 & bus.ACK1), 32'h0);
                ackWho[nAck] = bus.ACK1;
                ackAt[nAck]  = c;
                nAck++;
            end
        end
        bus.REQ0 = 0; bus.REQ1 = 0;
        compare("tie_ack_count", 32'(nAck), 32'd4);
        for (int k = 0; k < 4; k++) begin
            compare($sformatf("tie_winner%0d", k), 32'(ackWho[k]), 32'(k % 2));
            compare($sformatf("tie_ack_cycle%0d", k), 32'(ackAt[k]), 32'(4 + 5 * k));
        end
        compare("tie_rdata0", 32'(bus.RDATA0), 32'hBEEF);

        // Requester 0 held high across two writes: one masked IDLE, ACKs 6 apart.
        repeat (2) @(negedge clock);
        bus.REQ0 = 1; bus.WE0 = 1; bus.ADDR0 = 20'h00200; bus.WDATA0 = 16'h1111;
        nAck = 0;
        for (int k = 0; k < 4; k++) ackAt[k] = -1;
        for (int c = 1; c <= 30 && nAck < 2; c++) begin
            @(negedge clock);
            if (bus.ACK0) begin
                ackAt[nAck] = c;
                nAck++;
                bus.ADDR0  = 20'h00201;
                bus.WDATA0 = 16'h2222;
            end
        end
        bus.REQ0 = 0;
        compare("b2b_ack_count", 32'(nAck), 32'd2);
        compare("b2b_first_ack", 32'(ackAt[0]), 32'd4);
        compare("b2b_second_ack", 32'(ackAt[1]), 32'd10);
        compare("b2b_mem_first", 32'(mem[10'h200]), 32'h1111);
        compare("b2b_mem_second", 32'(mem[10'h201]), 32'h2222);

        // Reset during the STROBE cycle of a write: no ACK, pointer back to 1.
        repeat (2) @(negedge clock);
        bus.REQ0 = 1; bus.WE0 = 1; bus.ADDR0 = 20'h00300; bus.WDATA0 = 16'h3333;
        repeat (2) @(negedge clock);
        compare("rst_mid_in_strobe", 32'(strobesNow()), 32'(WR_ST));
        reset = 1'b1;
        bus.REQ0 = 0;
        @(negedge clock);
        compare("rst_mid_strobes", 32'(strobesNow()), 32'(IDLE_S));
        compare("rst_mid_addr", 32'(bus.SRAMaddress), 32'h0);
        reset = 1'b0;
        nAck = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (bus.ACK0 || bus.ACK1) nAck++;
        end
        compare("rst_mid_no_ack", 32'(nAck), 32'd0);

        bus.REQ0 = 1; bus.WE0 = 0; bus.ADDR0 = 20'h00123;
        bus.REQ1 = 1; bus.WE1 = 0; bus.ADDR1 = 20'h00123;
        nAck = 0;
        for (int k = 0; k < 4; k++) begin ackAt[k] = -1; ackWho[k] = 1'bx; end
        for (int c = 1; c <= 30 && nAck < 2; c++) begin
            @(negedge clock);
            if (bus.ACK0 || bus.ACK1) begin
                ackWho[nAck] = bus.ACK1;
                ackAt[nAck]  = c;
                nAck++;
                if (bus.ACK0) bus.REQ0 = 0;
            end
        end
        bus.REQ0 = 0; bus.REQ1 = 0;
        compare("post_rst_first_winner", 32'(ackWho[0]), 32'd0);
        compare("post_rst_first_ack", 32'(ackAt[0]), 32'd4);
        compare("post_rst_second_ack", 32'(ackAt[1]), 32'd9);
        compare("post_rst_rdata0", 32'(bus.RDATA0), 32'hBEEF);

        // Three extra wait cycles: ACK at cycle 6, nOE low in cycles 1..6.
        @(negedge clock);
        bus3.REQ0 = 1; bus3.WE0 = 0; bus3.ADDR0 = 20'h00042;
        ack3At  = -1;
        rd3     = 16'h0;
        noeMask = 16'h0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (!bus3.SRAM_nOE) noeMask[c] = 1'b1;
            if (bus3.ACK0 && ack3At < 0) begin
                ack3At    = c;
                rd3       = bus3.RDATA0;
                bus3.REQ0 = 0;
            end
        end
        bus3.REQ0 = 0;
        compare("wait3_ack_cycle", 32'(ack3At), 32'd6);
        compare("wait3_noe_cycles", 32'(noeMask), 32'h007E);
        compare("wait3_rdata0", 32'(rd3), 32'h5A5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_access_arbiter.md
# sram_access_arbiter

Shares the single DE2-115 external SRAM (IS61WV102416, 1M x 16) between two audio-effect requesters, such as the delay-line writer and a delay/reverb tap reader. Requests are granted round-robin and each one runs as a fixed-length read or write cycle with correct strobe sequencing. The block sits between the effects section and the SRAM pins, and is the only driver of the SRAM pins.

## Interface
- WAIT_CYCLES, default 1: extra STROBE cycles beyond the first; STROBE lasts WAIT_CYCLES+1 cycles; legal range 0..7.
- CLOCK50M  in  1  system clock, 50 MHz.
- RESET  in  1  synchronous, active-high reset.
- REQ0 / REQ1  in  1  access request; level, held until ACK.
- WE0 / WE1  in  1  1 = write, 0 = read; sampled at grant.
- ADDR0 / ADDR1  in  20  word address; sampled at grant.
- WDATA0 / WDATA1  in  16  write data; sampled at grant.
- ACK0 / ACK1  out  1  one-cycle completion pulse.
- RDATA0 / RDATA1  out  16  read data; valid from the ACK cycle until that requester's next read completes.
- BUSY  out  1  high in every state except IDLE.
- SRAMaddress  out  20  SRAM address.
- SRAMdata  inout  16  SRAM data; driven only during writes.
- SRAM_nCE, SRAM_nOE, SRAM_nWE, SRAM_nUB, SRAM_nLB  out  1 each  SRAM strobes, active low.

## Operation
- The FSM has four states: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- **IDLE**
  - All strobes are high and SRAMdata is Z.
  - If any unmasked REQ is high, grant it, latch its WE/ADDR/WDATA, then go to SETUP.
- **Arbitration**
  - If only one requester is asking, it wins.
  - If both are asking, the requester not served last wins.
  - The last-served pointer resets to 1, so requester 0 wins the first tie.
- **Mask rule**
  - A requester's REQ is ignored in the IDLE cycle immediately after its ACK.
  - A requester keeping REQ high after ACK is read as a new request, with its new payload, from the second cycle after ACK.
- **SETUP**
  - SRAMaddress = latched address.
  - nCE = nUB = nLB = 0.
  - nOE = 0 for reads, 1 for writes; nWE = 1.
  - On a write, SRAMdata is driven with the latched data.
- **STROBE**
  - Address and nCE/nUB/nLB/nOE are held.
  - On a write, nWE = 0.
  - A counter runs 0..WAIT_CYCLES; the FSM leaves STROBE when the count reaches WAIT_CYCLES.
  - On a read, SRAMdata is registered into an internal capture register on the final STROBE edge.
- **HOLD**
  - nWE = 1; nCE/nUB/nLB/nOE and the address are held.
  - On a write, SRAMdata is still driven (data hold time).
  - ACK of the granted requester = 1.
  - On a read, RDATA of the granted requester is loaded from the capture register.
  - Next state is IDLE unconditionally.
- **Reset**
  - Applies on any edge where RESET = 1, from any state, and takes priority over everything.
  - Next state is IDLE; the in-flight transaction is abandoned with no ACK.
  - Reset values:
    - SRAM strobes all 1, SRAMdata Z, SRAMaddress 0.
    - ACK0 = ACK1 = 0, RDATA0 = RDATA1 = 0, BUSY = 0.
    - Pointer = 1, STROBE counter = 0.
- **Protocol violation**
  - Changing REQ, WE, ADDR or WDATA after grant does not affect the running transaction.
  - Dropping REQ before ACK still completes the transaction, and ACK is still issued.

## Timing
- All outputs are registered.
- Let cycle 0 be the IDLE cycle in which REQ is sampled high. Then:
  - SETUP = cycle 1.
  - STROBE = cycles 2 .. 2+WAIT_CYCLES.
  - HOLD/ACK = cycle 3+WAIT_CYCLES; with the default this is cycle 4.
- Transaction period is 4+WAIT_CYCLES cycles; with the default, 5 cycles, i.e. 100 ns at 50 MHz.
- Worst-case wait for a requester facing a continuously requesting peer is one peer transaction plus its own: 2 x (4+WAIT_CYCLES) cycles.
- At 48 kHz (about 1041 cycles/sample) the worst case supports roughly 100 accesses per sample.
- SRAMdata changes direction only through IDLE, so a bus turnaround between a write and a following read is at least one cycle.
- An SRAM address change never coincides with nWE falling or rising: the address is stable from SETUP through HOLD.

## Test plan
- **Single write:** REQ0 = 1, WE0 = 1, ADDR0 = 20'h00123, WDATA0 = 16'hBEEF.
  - nWE is low for exactly cycles 2-3.
  - SRAMdata = BEEF through cycles 1-4.
  - ACK0 at cycle 4; BUSY is high in cycles 1-4.
- **Single read:** the SRAM model holds 16'h1234 at 20'h00123; REQ1 reads that address.
  - nOE is low for cycles 1-4; nWE stays high throughout.
  - SRAMdata is Z from the block.
  - RDATA1 = 1234 with ACK1 at cycle 4.
- **Tie:** REQ0 and REQ1 rise in the same cycle and both stay high.
  - Grants alternate 0,1,0,1.
  - ACKs occur 5 cycles apart.
  - Neither requester is granted twice in a row.
- **Back-to-back same requester:** REQ0 held high across two writes, with REQ1 low.
  - The second grant comes in the second cycle after ACK0 (one masked IDLE cycle).
  - ACK0 pulses are 6 cycles apart.
- **Reset mid-transaction:** RESET = 1 at cycle 2 of a write.
  - On the next edge all strobes are 1, SRAMdata is Z, and BUSY = 0.
  - No ACK is issued.
  - After reset, a tie with both requesters asking is granted to requester 0.
- **WAIT_CYCLES = 3:** a read completes with ACK at cycle 6, and nOE is low for cycles 1-6.
